// File: rtl/uart_pkg.sv
// Shared definitions for the configurable UART: parity modes, FSM state
// encoding, default bit timing and the parity helper.
package uart_pkg;

    // Parity selection values for c_PARITY
    localparam int c_PARITY_NONE = 0;
    localparam int c_PARITY_EVEN = 1;
    localparam int c_PARITY_ODD  = 2;

    // 50 MHz system clock at 115200 baud
    localparam int c_DEFAULT_CYCLES_PER_BIT = 434;

    // Widest payload any configuration can carry
    localparam int c_MAX_DATA_BITS = 9;

    // Transmit FSM state encoding
    localparam logic [2:0] c_ST_IDLE   = 3'd0;
    localparam logic [2:0] c_ST_START  = 3'd1;
    localparam logic [2:0] c_ST_DATA   = 3'd2;
    localparam logic [2:0] c_ST_PARITY = 3'd3;
    localparam logic [2:0] c_ST_STOP   = 3'd4;

    typedef enum logic [2:0] {
        ST_IDLE   = c_ST_IDLE,
        ST_START  = c_ST_START,
        ST_DATA   = c_ST_DATA,
        ST_PARITY = c_ST_PARITY,
        ST_STOP   = c_ST_STOP
    } tx_state_e;

    // Parity over a zero-extended payload; i_odd inverts the even result
    function automatic logic calc_parity(input logic [c_MAX_DATA_BITS-1:0] i_data,
                                         input logic i_odd);
        return (^i_data) ^ i_odd;
    endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Bit-period timer: counts 0..c_CYCLES_PER_BIT-1 while enabled and flags the
// cycle whose closing edge wraps the count back to 0. Shared by TX and RX.
module uart_bit_timer
    import uart_pkg::*;
#(
    parameter int c_CYCLES_PER_BIT = c_DEFAULT_CYCLES_PER_BIT
) (
    input  logic i_CLK,
    input  logic i_RESET,
    input  logic i_CLEAR,
    input  logic i_ENABLE,
    output logic o_BIT_TICK
);

    localparam int c_CNT_W = $clog2(c_CYCLES_PER_BIT);
    localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'(c_CYCLES_PER_BIT - 1);
    localparam logic [c_CNT_W-1:0] c_ONE  = c_CNT_W'(1);

    if (c_CYCLES_PER_BIT < 2) begin : g_bad_cycles
        $error("uart_bit_timer: c_CYCLES_PER_BIT must be at least 2");
    end

    logic [c_CNT_W-1:0] count_r;
    logic               wrap_s;

    // The tick is a strobe for the cycle in which the registered count is at
    // its last value, so the consumer advances on the same edge the count wraps.
    assign wrap_s     = i_ENABLE && (count_r == c_LAST);
    assign o_BIT_TICK = wrap_s;

    // Cycle counter within the current bit period
    always_ff @(posedge i_CLK or negedge i_RESET) begin
        if (!i_RESET) begin
            count_r <= '0;
        end else if (i_CLEAR) begin
            count_r <= '0;
        end else if (wrap_s) begin
            count_r <= '0;
        end else if (i_ENABLE) begin
            count_r <= count_r + c_ONE;
        end else begin
            count_r <= count_r;
        end
    end

endmodule

// File: rtl/uart_tx_cfg.sv
// Configurable UART transmitter: 5..9 data bits, none/even/odd parity,
// 1 or 2 stop bits, ready/valid handshake allowing back-to-back frames with
// a single idle-high cycle between the last stop bit and the next start bit.
module uart_tx_cfg
    import uart_pkg::*;
#(
    parameter int c_CYCLES_PER_BIT = c_DEFAULT_CYCLES_PER_BIT,
    parameter int c_DATA_BITS      = 8,
    parameter int c_PARITY         = c_PARITY_NONE,
    parameter int c_STOP_BITS      = 1
) (
    input  logic                   i_CLK,
    input  logic                   i_RESET,
    input  logic                   i_TX_DV,
    input  logic [c_DATA_BITS-1:0] i_PARALLEL_DATA,
    output logic                   o_TX_READY,
    output logic                   o_SERIAL_DATA,
    output logic                   o_TX_ACTIVE,
    output logic                   o_TX_DONE
);

    localparam int c_IDX_W = $clog2(c_DATA_BITS);
    localparam logic [c_IDX_W-1:0] c_LAST_IDX   = c_IDX_W'(c_DATA_BITS - 1);
    localparam logic [c_IDX_W-1:0] c_IDX_ONE    = c_IDX_W'(1);
    localparam logic               c_LAST_STOP  = 1'(c_STOP_BITS - 1);
    localparam logic               c_ODD        = (c_PARITY == c_PARITY_ODD) ? 1'b1 : 1'b0;
    localparam bit                 c_HAS_PARITY = (c_PARITY != c_PARITY_NONE);

    if ((c_DATA_BITS < 5) || (c_DATA_BITS > c_MAX_DATA_BITS)) begin : g_bad_data_bits
        $error("uart_tx_cfg: c_DATA_BITS must be in 5..9");
    end
    if ((c_PARITY != c_PARITY_NONE) && (c_PARITY != c_PARITY_EVEN) &&
        (c_PARITY != c_PARITY_ODD)) begin : g_bad_parity
        $error("uart_tx_cfg: c_PARITY must be 0, 1 or 2");
    end
    if ((c_STOP_BITS != 1) && (c_STOP_BITS != 2)) begin : g_bad_stop_bits
        $error("uart_tx_cfg: c_STOP_BITS must be 1 or 2");
    end
    if (c_CYCLES_PER_BIT < 2) begin : g_bad_cycles
        $error("uart_tx_cfg: c_CYCLES_PER_BIT must be at least 2");
    end

    tx_state_e              state_r;
    tx_state_e              state_next_s;
    logic [c_DATA_BITS-1:0] shift_r;
    logic [c_DATA_BITS-1:0] shift_next_s;
    logic                   parity_r;
    logic                   parity_next_s;
    logic [c_IDX_W-1:0]     idx_r;
    logic [c_IDX_W-1:0]     idx_next_s;
    logic                   stop_cnt_r;
    logic                   stop_cnt_next_s;
    logic                   serial_next_s;
    logic                   done_next_s;
    logic                   timer_clear_s;
    logic                   timer_en_s;
    logic                   bit_tick_s;
    logic                   serial_r;
    logic                   active_r;
    logic                   ready_r;
    logic                   done_r;

    assign timer_en_s = (state_r != ST_IDLE);

    uart_bit_timer #(
        .c_CYCLES_PER_BIT (c_CYCLES_PER_BIT)
    ) u_bit_timer (
        .i_CLK      (i_CLK),
        .i_RESET    (i_RESET),
        .i_CLEAR    (timer_clear_s),
        .i_ENABLE   (timer_en_s),
        .o_BIT_TICK (bit_tick_s)
    );

    // FSM state register
    always_ff @(posedge i_CLK or negedge i_RESET) begin
        if (!i_RESET) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state, datapath updates and the next line level derived from them
    always_comb begin
        state_next_s    = state_r;
        shift_next_s    = shift_r;
        parity_next_s   = parity_r;
        idx_next_s      = idx_r;
        stop_cnt_next_s = stop_cnt_r;
        done_next_s     = 1'b0;
        timer_clear_s   = 1'b0;
        serial_next_s   = 1'b1;

        case (state_r)
            ST_IDLE: begin
                if (i_TX_DV) begin
                    state_next_s    = ST_START;
                    shift_next_s    = i_PARALLEL_DATA;
                    parity_next_s   = calc_parity(c_MAX_DATA_BITS'(i_PARALLEL_DATA), c_ODD);
                    idx_next_s      = '0;
                    stop_cnt_next_s = 1'b0;
                    timer_clear_s   = 1'b1;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_START: begin
                if (bit_tick_s) begin
                    state_next_s = ST_DATA;
                end else begin
                    state_next_s = ST_START;
                end
            end
            ST_DATA: begin
                if (bit_tick_s) begin
                    shift_next_s = {1'b0, shift_r[c_DATA_BITS-1:1]};
                    if (idx_r == c_LAST_IDX) begin
                        idx_next_s   = '0;
                        state_next_s = c_HAS_PARITY ? ST_PARITY : ST_STOP;
                    end else begin
                        idx_next_s   = idx_r + c_IDX_ONE;
                    end
                end else begin
                    state_next_s = ST_DATA;
                end
            end
            ST_PARITY: begin
                if (bit_tick_s) begin
                    state_next_s = ST_STOP;
                end else begin
                    state_next_s = ST_PARITY;
                end
            end
            ST_STOP: begin
                if (bit_tick_s) begin
                    if (stop_cnt_r == c_LAST_STOP) begin
                        state_next_s    = ST_IDLE;
                        stop_cnt_next_s = 1'b0;
                        done_next_s     = 1'b1;
                    end else begin
                        stop_cnt_next_s = stop_cnt_r + 1'b1;
                    end
                end else begin
                    state_next_s = ST_STOP;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase

        // Line level for the state being entered, so the output register
        // switches on the same edge as the state.
        case (state_next_s)
            ST_IDLE:   serial_next_s = 1'b1;
            ST_START:  serial_next_s = 1'b0;
            ST_DATA:   serial_next_s = shift_next_s[0];
            ST_PARITY: serial_next_s = parity_next_s;
            ST_STOP:   serial_next_s = 1'b1;
            default:   serial_next_s = 1'b1;
        endcase
    end

    // Shift register, parity bit, bit index and stop-bit counter
    always_ff @(posedge i_CLK or negedge i_RESET) begin
        if (!i_RESET) begin
            shift_r    <= '0;
            parity_r   <= 1'b0;
            idx_r      <= '0;
            stop_cnt_r <= 1'b0;
        end else begin
            shift_r    <= shift_next_s;
            parity_r   <= parity_next_s;
            idx_r      <= idx_next_s;
            stop_cnt_r <= stop_cnt_next_s;
        end
    end

    // Registered outputs; reset drives the line high immediately
    always_ff @(posedge i_CLK or negedge i_RESET) begin
        if (!i_RESET) begin
            serial_r <= 1'b1;
            active_r <= 1'b0;
            ready_r  <= 1'b1;
            done_r   <= 1'b0;
        end else begin
            serial_r <= serial_next_s;
            active_r <= (state_next_s != ST_IDLE);
            ready_r  <= (state_next_s == ST_IDLE);
            done_r   <= done_next_s;
        end
    end

    assign o_SERIAL_DATA = serial_r;
    assign o_TX_ACTIVE   = active_r;
    assign o_TX_READY    = ready_r;
    assign o_TX_DONE     = done_r;

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Self-checking bench for uart_tx_cfg across four configurations
// (8N1 @434, 7O2 @4, 8E1 @3, 9O1 @2). Expected line levels come from a frame
// model built out of the payload bits and the configuration.
module tb_uart_tx_cfg;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] dv;
    logic [3:0] ser;
    logic [3:0] act;
    logic [3:0] rdy;
    logic [3:0] dn;
    logic [8:0] pdata [4];

    int checks = 0;
    int errors = 0;

    int cpb_a   [4] = '{434, 4, 3, 2};
    int nbits_a [4] = '{8, 7, 8, 9};
    int par_a   [4] = '{0, 2, 1, 2};
    int stop_a  [4] = '{1, 2, 1, 1};

    always #5 clk = ~clk;

    uart_tx_cfg #(.c_CYCLES_PER_BIT(434), .c_DATA_BITS(8), .c_PARITY(0), .c_STOP_BITS(1)) u_dut0 (
        .i_CLK(clk), .i_RESET(rst_n), .i_TX_DV(dv[0]), .i_PARALLEL_DATA(pdata[0][7:0]),
        .o_TX_READY(rdy[0]), .o_SERIAL_DATA(ser[0]), .o_TX_ACTIVE(act[0]), .o_TX_DONE(dn[0]));

    uart_tx_cfg #(.c_CYCLES_PER_BIT(4), .c_DATA_BITS(7), .c_PARITY(2), .c_STOP_BITS(2)) u_dut1 (
        .i_CLK(clk), .i_RESET(rst_n), .i_TX_DV(dv[1]), .i_PARALLEL_DATA(pdata[1][6:0]),
        .o_TX_READY(rdy[1]), .o_SERIAL_DATA(ser[1]), .o_TX_ACTIVE(act[1]), .o_TX_DONE(dn[1]));

    uart_tx_cfg #(.c_CYCLES_PER_BIT(3), .c_DATA_BITS(8), .c_PARITY(1), .c_STOP_BITS(1)) u_dut2 (
        .i_CLK(clk), .i_RESET(rst_n), .i_TX_DV(dv[2]), .i_PARALLEL_DATA(pdata[2][7:0]),
        .o_TX_READY(rdy[2]), .o_SERIAL_DATA(ser[2]), .o_TX_ACTIVE(act[2]), .o_TX_DONE(dn[2]));

    uart_tx_cfg #(.c_CYCLES_PER_BIT(2), .c_DATA_BITS(9), .c_PARITY(2), .c_STOP_BITS(1)) u_dut3 (
        .i_CLK(clk), .i_RESET(rst_n), .i_TX_DV(dv[3]), .i_PARALLEL_DATA(pdata[3][8:0]),
        .o_TX_READY(rdy[3]), .o_SERIAL_DATA(ser[3]), .o_TX_ACTIVE(act[3]), .o_TX_DONE(dn[3]));

    task automatic check(input string tag, input int sel, input int cyc,
                         input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s dut%0d cycle %0d: observed %b expected %b", tag, sel, cyc, obs, exp);
        end
    endtask

    task automatic check_outs(input int sel, input int cyc, input logic e_ser,
                              input logic e_act, input logic e_rdy, input logic e_dn);
        check("serial", sel, cyc, ser[sel], e_ser);
        check("active", sel, cyc, act[sel], e_act);
        check("ready",  sel, cyc, rdy[sel], e_rdy);
        check("done",   sel, cyc, dn[sel],  e_dn);
    endtask

    // Idle for n cycles starting from a negedge; the line must stay quiet
    task automatic idle(input int sel, input int n);
        dv[sel] = 1'b0;
        for (int j = 0; j < n; j++) begin
            @(negedge clk);
            check_outs(sel, j, 1'b1, 1'b0, 1'b1, 1'b0);
        end
    endtask

    // Send one frame from a negedge in an idle/done cycle and check every
    // cycle of it. mode 0: dv dropped after acceptance; 1: random dv and data
    // noise while busy; 2: dv held high throughout. abort_at >= 0 asserts
    // reset at that frame cycle and returns after release.
    task automatic run_frame(input int sel, input logic [8:0] data,
                             input int mode, input int abort_at);
        logic       fbits [16];
        logic [8:0] d;
        logic [8:0] mask;
        int         nb;
        int         c;
        int         nf;
        int         ones;

        nb   = nbits_a[sel];
        c    = cpb_a[sel];
        mask = (9'h001 << nb) - 9'h001;
        d    = data & mask;
        ones = $countones(d);
        nf   = 0;
        fbits[nf] = 1'b0;
        nf++;
        for (int i = 0; i < nb; i++) begin
            fbits[nf] = d[i];
            nf++;
        end
        if (par_a[sel] != 0) begin
            fbits[nf] = ((ones % 2) == 1) ^ (par_a[sel] == 2);
            nf++;
        end
        for (int i = 0; i < stop_a[sel]; i++) begin
            fbits[nf] = 1'b1;
            nf++;
        end

        check("ready_before_accept", sel, -1, rdy[sel], 1'b1);
        pdata[sel] = d;
        dv[sel]    = 1'b1;

        for (int j = 0; j < nf * c; j++) begin
            @(negedge clk);
            check_outs(sel, j, fbits[j / c], 1'b1, 1'b0, 1'b0);
            if (j == abort_at) begin
                rst_n = 1'b0;
                #1;
                check_outs(sel, j, 1'b1, 1'b0, 1'b1, 1'b0);
                @(negedge clk);
                dv[sel] = 1'b0;
                rst_n   = 1'b1;
                return;
            end
            if (mode == 1 && j < nf * c - 1) begin
                dv[sel]    = 1'($urandom_range(0, 1));
                pdata[sel] = ((j % 2) == 1) ? 9'h1FF : 9'($urandom);
            end else if (mode == 2) begin
                dv[sel] = 1'b1;
            end else begin
                dv[sel] = 1'b0;
            end
        end

        @(negedge clk);
        check_outs(sel, nf * c, 1'b1, 1'b0, 1'b1, 1'b1);
    endtask

    initial begin
        int gap;
        int mode;

        rst_n = 1'b0;
        dv    = 4'b0000;
        for (int i = 0; i < 4; i++) pdata[i] = 9'h000;

        repeat (3) @(negedge clk);
        for (int s = 0; s < 4; s++) check_outs(s, 0, 1'b1, 1'b0, 1'b1, 1'b0);
        rst_n = 1'b1;
        idle(0, 2);

        // 8N1 at full rate: 0x27, done 4340 cycles after acceptance
        run_frame(0, 9'h027, 0, -1);
        idle(0, 3);

        // dv held high: 0xA5 then 0x3C back to back
        run_frame(0, 9'h0A5, 2, -1);
        run_frame(0, 9'h03C, 2, -1);
        idle(0, 3);

        // 0x00 with dv pulses and 0xFF/random data while busy
        run_frame(0, 9'h000, 1, -1);
        idle(0, 2);

        // reset in the middle of data bit 3, then a clean 0x27
        run_frame(0, 9'h027, 0, 4 * 434 + 217);
        idle(0, 3);
        run_frame(0, 9'h027, 0, -1);
        idle(0, 2);

        // directed parity cases on the short-period instances
        run_frame(2, 9'h027, 0, -1);
        idle(2, 2);
        run_frame(3, 9'h027, 0, -1);
        idle(3, 2);
        run_frame(1, 9'h055, 0, -1);
        idle(1, 2);

        // random payloads, handshake modes and gaps
        for (int s = 1; s < 4; s++) begin
            for (int k = 0; k < 10; k++) begin
                mode = int'($urandom_range(0, 2));
                run_frame(s, 9'($urandom), mode, -1);
                gap = int'($urandom_range(0, 2));
                if (gap > 0) idle(s, gap);
            end
            idle(s, 2);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
